// File: rtl/nt_node_stimulus_gen_pkg.sv
// ---------------------------------------------------------------------------
// nt_stim_pkg
// Shared types and default constants for the Nt_Node LFSR stimulus generator.
//   state_e      : control FSM states (IDLE, LOAD, RUN, DONE)
//   DEF_*        : default widths and Galois feedback taps
// ---------------------------------------------------------------------------
package nt_stim_pkg;

    localparam int          DEF_LFSR_W = 16;
    localparam logic [15:0] DEF_POLY   = 16'hB400;
    localparam int          DEF_OUT_W  = 4;
    localparam int          DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/nt_node_stimulus_gen_if.sv
// ---------------------------------------------------------------------------
// nt_node_stimulus_gen_if
// Control and vector-stream bundle between bench control, the stimulus
// generator and the subcircuit under test.
//   start, abort, seed, num_pat : run control into the generator
//   vec, vec_valid / vec_ready  : valid/ready vector stream
//   busy, done, sent            : run status out of the generator
// modport master : the generator side
// modport slave  : the controller / consumer side
// ---------------------------------------------------------------------------
interface nt_node_stimulus_gen_if
    import nt_stim_pkg::*;
#(
    parameter int LFSR_W = DEF_LFSR_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int CNT_W  = DEF_CNT_W
) ();

    logic              start;
    logic              abort;
    logic [LFSR_W-1:0] seed;
    logic [CNT_W-1:0]  num_pat;
    logic [OUT_W-1:0]  vec;
    logic              vec_valid;
    logic              vec_ready;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  sent;

    modport master (
        input  start, abort, seed, num_pat, vec_ready,
        output vec, vec_valid, busy, done, sent
    );

    modport slave (
        output start, abort, seed, num_pat, vec_ready,
        input  vec, vec_valid, busy, done, sent
    );

endinterface

// File: rtl/nt_node_stimulus_gen_lfsr.sv
// ---------------------------------------------------------------------------
// nt_lfsr_galois
// Right-shifting Galois LFSR. Resets to 1; a zero seed is replaced by 1 so the
// register can never enter the all-zero lock-up state.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load, i_seed : load seed (takes priority over advance)
//   i_advance      : step one position
//   o_vec          : low OUT_W bits of the current state
//   o_next_vec     : low OUT_W bits of the state after one step
// ---------------------------------------------------------------------------
module nt_lfsr_galois #(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] POLY   = 16'hB400,
    parameter int                OUT_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_advance,
    output logic [OUT_W-1:0]  o_vec,
    output logic [OUT_W-1:0]  o_next_vec
);

    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_lfsr_next;

    assign w_lfsr_next = {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? POLY : '0);

    // NOTE: flops are written with <= so every always_ff reads the pre-edge
    // value of every register regardless of evaluation order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= LFSR_W'(1);
        end else if (i_load) begin
            r_lfsr <= (i_seed == '0) ? LFSR_W'(1) : i_seed;
        end else if (i_advance) begin
            r_lfsr <= w_lfsr_next;
        end
    end

    assign o_vec      = r_lfsr[OUT_W-1:0];
    assign o_next_vec = w_lfsr_next[OUT_W-1:0];

endmodule

// File: rtl/nt_node_stimulus_gen.sv
// ---------------------------------------------------------------------------
// nt_node_stimulus_gen
// LFSR vector source for the Nt_Node subcircuit benches. A start pulse in IDLE
// captures seed and num_pat; the block then emits exactly num_pat vectors
// over a valid/ready link and pulses done. abort returns to IDLE at any time.
//   I1470 : clock (rising edge)
//   I1477 : asynchronous active-low reset
//   bus   : nt_node_stimulus_gen_if.master (control, vector stream, status)
// OUT_W must not exceed LFSR_W.
// ---------------------------------------------------------------------------
module nt_node_stimulus_gen
    import nt_stim_pkg::*;
#(
    parameter int                LFSR_W = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0] POLY   = DEF_POLY,
    parameter int                OUT_W  = DEF_OUT_W,
    parameter int                CNT_W  = DEF_CNT_W
) (
    input  logic                    I1470,
    input  logic                    I1477,
    nt_node_stimulus_gen_if.master  bus
);

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_sent;
    logic [OUT_W-1:0] r_vec;
    logic             r_vec_valid;

    logic             w_start_ok;
    logic             w_xfer;
    logic             w_last;
    logic             w_busy;
    logic             w_done;
    logic [OUT_W-1:0] w_lfsr_vec;
    logic [OUT_W-1:0] w_lfsr_next_vec;

    // abort wins over a simultaneous start
    assign w_start_ok = (r_state == IDLE) && bus.start && !bus.abort;
    assign w_xfer     = r_vec_valid && bus.vec_ready;
    assign w_last     = w_xfer && (r_remaining == CNT_W'(1));

    // Seed is loaded on the accepting edge, so in LOAD the LFSR already holds
    // it and the first vector can be registered out of LOAD.
    nt_lfsr_galois #(
        .LFSR_W (LFSR_W),
        .POLY   (POLY),
        .OUT_W  (OUT_W)
    ) u_lfsr (
        .i_clk      (I1470),
        .i_rst_n    (I1477),
        .i_load     (w_start_ok),
        .i_seed     (bus.seed),
        .i_advance  (w_xfer && !w_last),
        .o_vec      (w_lfsr_vec),
        .o_next_vec (w_lfsr_next_vec)
    );

    always_ff @(posedge I1470 or negedge I1477) begin
        if (!I1477) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: if (w_start_ok) w_state_next = LOAD;
            LOAD: begin
                w_busy       = 1'b1;
                w_state_next = (r_remaining == '0) ? DONE : RUN;
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        if (bus.abort) w_state_next = IDLE;
    end

    // Later assignments in this block override earlier ones on the same edge:
    // the last transfer and abort both force vec_valid low.
    always_ff @(posedge I1470 or negedge I1477) begin
        if (!I1477) begin
            r_remaining <= '0;
            r_sent      <= '0;
            r_vec       <= '0;
            r_vec_valid <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_remaining <= bus.num_pat;
                r_sent      <= '0;
            end
            if (r_state == LOAD) begin
                r_vec       <= w_lfsr_vec;
                r_vec_valid <= (r_remaining != '0);
            end
            if (w_xfer) begin
                r_sent      <= r_sent + CNT_W'(1);
                r_remaining <= r_remaining - CNT_W'(1);
                if (w_last) r_vec_valid <= 1'b0;
                else        r_vec       <= w_lfsr_next_vec;
            end
            if (bus.abort) r_vec_valid <= 1'b0;
        end
    end

    assign bus.vec       = r_vec;
    assign bus.vec_valid = r_vec_valid;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.sent      = r_sent;

endmodule

// File: tb/tb_nt_node_stimulus_gen.sv
// ---------------------------------------------------------------------------
// tb_nt_node_stimulus_gen
// Scenario bench for nt_node_stimulus_gen. Expected vectors are queued when a
// run is launched and popped as the DUT completes each transfer.
// ---------------------------------------------------------------------------
module tb_nt_node_stimulus_gen;

    localparam int LW = 16;
    localparam int OW = 4;
    localparam int CW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    nt_node_stimulus_gen_if #(.LFSR_W(LW), .OUT_W(OW), .CNT_W(CW)) bus_if ();

    nt_node_stimulus_gen #(
        .LFSR_W (LW),
        .POLY   (16'hB400),
        .OUT_W  (OW),
        .CNT_W  (CW)
    ) dut (
        .I1470 (clk),
        .I1477 (rst_n),
        .bus   (bus_if)
    );

    int            n_vec = 0;
    int            n_err = 0;
    logic [OW-1:0] exp_q[$];
    int            xfers, dones, busy_cyc, valid_cyc;

    function automatic logic [15:0] model_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic push_model(input logic [15:0] seed, input int n);
        logic [15:0] s;
        s = (seed == 16'h0000) ? 16'h0001 : seed;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(s[OW-1:0]);
            s = model_step(s);
        end
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 of the LOAD cycle.
    task automatic start_run(input logic [15:0] seed, input logic [15:0] n);
        bus_if.seed    = seed;
        bus_if.num_pat = n;
        bus_if.start   = 1'b1;
        @(posedge clk); #1;
        bus_if.start   = 1'b0;
    endtask

    // Runs the consumer side until done, or until stop_after transfers.
    task automatic collect(input int stall_idx, input int stall_len, input int stop_after);
        int            stalled;
        logic          prev_hold;
        logic [OW-1:0] prev_vec;
        logic [OW-1:0] exp_v;
        xfers = 0; dones = 0; busy_cyc = 0; valid_cyc = 0;
        stalled = 0; prev_hold = 1'b0; prev_vec = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (xfers == stall_idx && stalled < stall_len) begin
                bus_if.vec_ready = 1'b0;
                stalled++;
            end else begin
                bus_if.vec_ready = 1'b1;
            end
            @(negedge clk);
            if (bus_if.busy === 1'b1) busy_cyc++;
            if (bus_if.done === 1'b1) dones++;
            if (prev_hold) begin
                n_vec++;
                if (bus_if.vec_valid !== 1'b1 || bus_if.vec !== prev_vec) begin
                    n_err++;
                    $display("FAIL hold_stable: valid=%b vec=%h, required valid=1 vec=%h",
                             bus_if.vec_valid, bus_if.vec, prev_vec);
                end
            end
            if (bus_if.vec_valid === 1'b1 && bus_if.vec_ready) begin
                valid_cyc++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL vec_extra: vec=%h offered and taken, required no transfer", bus_if.vec);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (bus_if.vec !== exp_v) begin
                        n_err++;
                        $display("FAIL vec[%0d]: got %h, required %h", xfers, bus_if.vec, exp_v);
                    end
                end
                xfers++;
            end else if (bus_if.vec_valid === 1'b1) begin
                valid_cyc++;
            end
            prev_hold = (bus_if.vec_valid === 1'b1) && !bus_if.vec_ready;
            prev_vec  = bus_if.vec;
            @(posedge clk); #1;
            if (dones > 0 || xfers == stop_after) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL timeout: no done after 200 cycles, xfers=%0d", xfers);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({bus_if.vec, bus_if.vec_valid, bus_if.busy, bus_if.done, bus_if.sent} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: vec=%h valid=%b busy=%b done=%b sent=%0d, required all 0",
                     bus_if.vec, bus_if.vec_valid, bus_if.busy, bus_if.done, bus_if.sent);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Shared post-run tally: transfers, done pulses, busy cycles, valid cycles.
    task automatic test_basic();
        exp_q.push_back(4'h1); exp_q.push_back(4'h0);
        exp_q.push_back(4'h8); exp_q.push_back(4'hC);
        start_run(16'hACE1, 16'd4);
        collect(-1, 0, -1);
        n_vec++;
        if ({xfers, dones, busy_cyc, valid_cyc} !== {32'd4, 32'd1, 32'd5, 32'd4}) begin
            n_err++;
            $display("FAIL basic_tally: xfers=%0d done=%0d busy=%0d valid=%0d, required 4 1 5 4",
                     xfers, dones, busy_cyc, valid_cyc);
        end
        @(negedge clk);
        n_vec++;
        if ({bus_if.done, bus_if.vec_valid, bus_if.busy, bus_if.sent} !== {3'b000, 16'd4}) begin
            n_err++;
            $display("FAIL basic_after: done=%b valid=%b busy=%b sent=%0d, required 0 0 0 4",
                     bus_if.done, bus_if.vec_valid, bus_if.busy, bus_if.sent);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        exp_q.push_back(4'h1); exp_q.push_back(4'h0);
        exp_q.push_back(4'h8); exp_q.push_back(4'hC);
        start_run(16'hACE1, 16'd4);
        collect(1, 3, -1);
        n_vec++;
        if ({xfers, dones, busy_cyc, valid_cyc} !== {32'd4, 32'd1, 32'd8, 32'd7}) begin
            n_err++;
            $display("FAIL stall_tally: xfers=%0d done=%0d busy=%0d valid=%0d, required 4 1 8 7",
                     xfers, dones, busy_cyc, valid_cyc);
        end
        n_vec++;
        if (bus_if.sent !== 16'd4) begin
            n_err++;
            $display("FAIL stall_sent: got %0d, required 4", bus_if.sent);
        end
    endtask

    task automatic test_zero();
        start_run(16'h1234, 16'd0);
        collect(-1, 0, -1);
        n_vec++;
        if ({xfers, dones, busy_cyc, valid_cyc} !== {32'd0, 32'd1, 32'd1, 32'd0}) begin
            n_err++;
            $display("FAIL zero_tally: xfers=%0d done=%0d busy=%0d valid=%0d, required 0 1 1 0",
                     xfers, dones, busy_cyc, valid_cyc);
        end
        n_vec++;
        if (bus_if.sent !== 16'd0) begin
            n_err++;
            $display("FAIL zero_sent: got %0d, required 0", bus_if.sent);
        end
    endtask

    task automatic test_seed_zero();
        exp_q.push_back(4'h1); exp_q.push_back(4'h0); exp_q.push_back(4'h0);
        start_run(16'h0000, 16'd3);
        collect(-1, 0, -1);
        n_vec++;
        if ({xfers, dones, busy_cyc, valid_cyc} !== {32'd3, 32'd1, 32'd4, 32'd3}) begin
            n_err++;
            $display("FAIL seed0_tally: xfers=%0d done=%0d busy=%0d valid=%0d, required 3 1 4 3",
                     xfers, dones, busy_cyc, valid_cyc);
        end
        n_vec++;
        if (bus_if.sent !== 16'd3) begin
            n_err++;
            $display("FAIL seed0_sent: got %0d, required 3", bus_if.sent);
        end
    endtask

    task automatic test_abort();
        int done_seen;
        push_model(16'h1234, 10);
        start_run(16'h1234, 16'd10);
        collect(-1, 0, 2);
        bus_if.vec_ready = 1'b0;
        bus_if.abort     = 1'b1;
        @(posedge clk); #1;
        bus_if.abort     = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus_if.busy, bus_if.vec_valid, bus_if.done, bus_if.sent} !== {3'b000, 16'd2}) begin
            n_err++;
            $display("FAIL abort_idle: busy=%b valid=%b done=%b sent=%0d, required 0 0 0 2",
                     bus_if.busy, bus_if.vec_valid, bus_if.done, bus_if.sent);
        end
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) done_seen++;
        end
        n_vec++;
        if (done_seen != 0) begin
            n_err++;
            $display("FAIL abort_no_done: done seen %0d times, required 0", done_seen);
        end
        exp_q.delete();
        // start and abort together in IDLE: abort wins
        @(posedge clk); #1;
        bus_if.start = 1'b1;
        bus_if.abort = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus_if.busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_abort_same: busy=%b, required 0", bus_if.busy);
        end
        @(posedge clk); #1;
        push_model(16'h00FF, 5);
        start_run(16'h00FF, 16'd5);
        collect(-1, 0, -1);
        n_vec++;
        if ({xfers, dones, busy_cyc, valid_cyc, 16'(bus_if.sent)} !==
            {32'd5, 32'd1, 32'd6, 32'd5, 16'd5}) begin
            n_err++;
            $display("FAIL restart_tally: xfers=%0d done=%0d busy=%0d valid=%0d sent=%0d, required 5 1 6 5 5",
                     xfers, dones, busy_cyc, valid_cyc, bus_if.sent);
        end
    endtask

    task automatic test_reset_midrun();
        push_model(16'hBEEF, 20);
        start_run(16'hBEEF, 16'd20);
        collect(-1, 0, 3);
        // start while busy must not disturb the running sequence
        bus_if.vec_ready = 1'b0;
        bus_if.seed      = 16'h1111;
        bus_if.num_pat   = 16'd2;
        bus_if.start     = 1'b1;
        @(posedge clk); #1;
        bus_if.start     = 1'b0;
        collect(-1, 0, 2);
        bus_if.vec_ready = 1'b0;
        n_vec++;
        if ({bus_if.busy, bus_if.vec_valid, bus_if.sent} !== {2'b11, 16'd5}) begin
            n_err++;
            $display("FAIL busy_start_ignored: busy=%b valid=%b sent=%0d, required 1 1 5",
                     bus_if.busy, bus_if.vec_valid, bus_if.sent);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus_if.vec, bus_if.vec_valid, bus_if.busy, bus_if.done, bus_if.sent} !== '0) begin
            n_err++;
            $display("FAIL midrun_reset: vec=%h valid=%b busy=%b done=%b sent=%0d, required all 0",
                     bus_if.vec, bus_if.vec_valid, bus_if.busy, bus_if.done, bus_if.sent);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++;
        if ({bus_if.busy, bus_if.done, bus_if.vec_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL post_reset_idle: busy=%b done=%b valid=%b, required 0 0 0",
                     bus_if.busy, bus_if.done, bus_if.vec_valid);
        end
    endtask

    initial begin
        bus_if.start     = 1'b0;
        bus_if.abort     = 1'b0;
        bus_if.seed      = '0;
        bus_if.num_pat   = '0;
        bus_if.vec_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_seed_zero();
        test_abort();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
